// File: rtl/isb_pf_queue.sv
// isb_pf_queue: prefetch issue queue behind the ISB prefetcher.
// Filters duplicates/demanded addresses, buffers in order, issues to memory.
module isb_pf_queue #(
  parameter int DEPTH = 4,
  parameter int FILT  = 4,
  parameter int AW    = 16,
  parameter int CW    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pf_v,
  input  logic [AW-1:0]                pf_addr,
  input  logic                         dem_v,
  input  logic [AW-1:0]                dem_addr,
  output logic                         mem_req_v,
  output logic [AW-1:0]                mem_req_addr,
  input  logic                         mem_req_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CW-1:0]                dup_cnt,
  output logic [CW-1:0]                ovf_cnt
);

  localparam int OW = $clog2(DEPTH+1);
  localparam int PW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [DEPTH-1:0] q_v;
  logic [AW-1:0]    q_a [DEPTH];
  logic [FILT-1:0]  f_v;
  logic [AW-1:0]    f_a [FILT];
  logic [PW-1:0]    fptr;

  logic             pop;
  logic [DEPTH-1:0] sq;
  logic [DEPTH-1:0] keep;
  logic             hit;
  logic             dup;
  logic             full;
  logic             ovf;
  logic             push;

  logic [DEPTH-1:0] n_v;
  logic [AW-1:0]    n_a [DEPTH];
  int               cnt;

  assign pop = q_v[0] & mem_req_ready;

  // the head has already been offered, so only later slots can be squashed
  always_comb begin
    sq   = '0;
    keep = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0)
        sq[i] = dem_v && q_v[i] && (q_a[i] == dem_addr);
      keep[i] = q_v[i] && !sq[i];
    end
    keep[0] = q_v[0] && !pop;
  end

  always_comb begin
    hit = dem_v && (dem_addr == pf_addr);
    for (int i = 0; i < DEPTH; i++)
      if (q_v[i] && (q_a[i] == pf_addr))
        hit = 1'b1;
    for (int j = 0; j < FILT; j++)
      if (f_v[j] && (f_a[j] == pf_addr))
        hit = 1'b1;
  end

  assign dup  = pf_v & hit;
  assign full = &q_v;
  assign ovf  = pf_v & ~dup & full & ~pop & ~(|sq);
  assign push = pf_v & ~dup & ~ovf;

  // survivors compact toward slot 0; the new entry lands after them
  always_comb begin
    n_v = '0;
    for (int j = 0; j < DEPTH; j++)
      n_a[j] = '0;
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (j == cnt) begin
            n_v[j] = 1'b1;
            n_a[j] = q_a[i];
          end
        end
        cnt = cnt + 1;
      end
    end
    if (push) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j == cnt) begin
          n_v[j] = 1'b1;
          n_a[j] = pf_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_v       <= '0;
      f_v       <= '0;
      fptr      <= '0;
      occupancy <= '0;
      dup_cnt   <= '0;
      ovf_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++)
        q_a[i] <= '0;
      for (int j = 0; j < FILT; j++)
        f_a[j] <= '0;
    end else begin
      q_v <= n_v;
      for (int i = 0; i < DEPTH; i++)
        q_a[i] <= n_a[i];
      occupancy <= OW'(cnt + (push ? 1 : 0));
      if (pop) begin
        f_v[fptr] <= 1'b1;
        f_a[fptr] <= q_a[0];
        fptr <= (fptr == PW'(FILT-1)) ? '0 : fptr + 1'b1;
      end
      if (dup && (dup_cnt != {CW{1'b1}}))
        dup_cnt <= dup_cnt + 1'b1;
      if (ovf && (ovf_cnt != {CW{1'b1}}))
        ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign mem_req_v    = q_v[0];
  assign mem_req_addr = q_a[0];

endmodule

// File: tb/tb_isb_pf_queue.sv
// tb_isb_pf_queue: directed stimulus with a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_isb_pf_queue;

  localparam int DEPTH = 4;
  localparam int FILT  = 4;
  localparam int CMAX  = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pf_v;
  logic [15:0] pf_addr;
  logic        dem_v;
  logic [15:0] dem_addr;
  logic        mem_req_v;
  logic [15:0] mem_req_addr;
  logic        mem_req_ready;
  logic [2:0]  occupancy;
  logic [7:0]  dup_cnt;
  logic [7:0]  ovf_cnt;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  isb_pf_queue #(.DEPTH(DEPTH), .FILT(FILT), .AW(16), .CW(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pf_v(pf_v),
    .pf_addr(pf_addr),
    .dem_v(dem_v),
    .dem_addr(dem_addr),
    .mem_req_v(mem_req_v),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .occupancy(occupancy),
    .dup_cnt(dup_cnt),
    .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // reference model
  logic [15:0] mq [$];
  logic [15:0] fa [FILT];
  bit          fv [FILT];
  int          fp;
  int          md;
  int          mo;
  bit          m_pop, m_hit, m_dup, m_ovf;
  int          m_sq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      for (int j = 0; j < FILT; j++) begin
        fv[j] = 0;
        fa[j] = '0;
      end
      fp = 0;
      md = 0;
      mo = 0;
    end else begin
      m_pop = (mq.size() > 0) && mem_req_ready;
      m_hit = dem_v && (dem_addr == pf_addr);
      foreach (mq[i])
        if (mq[i] == pf_addr) m_hit = 1;
      for (int j = 0; j < FILT; j++)
        if (fv[j] && fa[j] == pf_addr) m_hit = 1;
      m_dup = pf_v && m_hit;
      m_sq = -1;
      if (dem_v)
        for (int i = 1; i < mq.size(); i++)
          if (mq[i] == dem_addr) m_sq = i;
      m_ovf = pf_v && !m_dup && (mq.size() == DEPTH) && !m_pop && (m_sq < 0);
      if (m_dup) md = (md == CMAX) ? CMAX : md + 1;
      if (m_ovf) mo = (mo == CMAX) ? CMAX : mo + 1;
      if (m_sq >= 0) mq.delete(m_sq);
      if (m_pop) begin
        fa[fp] = mq[0];
        fv[fp] = 1;
        fp = (fp + 1) % FILT;
        void'(mq.pop_front());
      end
      if (pf_v && !m_dup && !m_ovf) mq.push_back(pf_addr);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req_v", int'(mem_req_v), (mq.size() > 0) ? 1 : 0);
      chk("m_req_addr", int'(mem_req_addr), (mq.size() > 0) ? int'(mq[0]) : 0);
      chk("m_occ", int'(occupancy), mq.size());
      chk("m_dup", int'(dup_cnt), md);
      chk("m_ovf", int'(ovf_cnt), mo);
    end
  end

  task automatic cyc(input logic pv, input logic [15:0] pa,
                     input logic dv, input logic [15:0] da,
                     input logic rdy);
    pf_v = pv;
    pf_addr = pa;
    dem_v = dv;
    dem_addr = da;
    mem_req_ready = rdy;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int hv, input int ha, input int oc);
    chk({name, "_v"}, int'(mem_req_v), hv);
    chk({name, "_addr"}, int'(mem_req_addr), ha);
    chk({name, "_occ"}, int'(occupancy), oc);
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    @(negedge clk);
    pf_v = 0;
    dem_v = 0;
    mem_req_ready = 0;
    rst_n = 1;
  endtask

  initial begin
    pf_v = 0;
    pf_addr = 0;
    dem_v = 0;
    dem_addr = 0;
    mem_req_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    lit("rst", 0, 0, 0);
    chk("rst_dup", int'(dup_cnt), 0);
    chk("rst_ovf", int'(ovf_cnt), 0);

    // 1: single entry, held while not ready, then popped
    cyc(1, 16'h0100, 0, 0, 0);
    lit("t1_push", 1, 'h100, 1);
    cyc(0, 0, 0, 0, 0);
    lit("t1_hold", 1, 'h100, 1);
    cyc(0, 0, 0, 0, 1);
    lit("t1_pop", 0, 0, 0);

    // 2: fill, overflow, then push with pop on full
    cyc(1, 16'h0010, 0, 0, 0);
    cyc(1, 16'h0020, 0, 0, 0);
    cyc(1, 16'h0030, 0, 0, 0);
    cyc(1, 16'h0040, 0, 0, 0);
    lit("t2_full", 1, 'h10, 4);
    cyc(1, 16'h0050, 0, 0, 0);
    lit("t2_ovf", 1, 'h10, 4);
    chk("t2_ovf_cnt", int'(ovf_cnt), 1);
    cyc(1, 16'h0050, 0, 0, 1);
    lit("t2_pp", 1, 'h20, 4);
    chk("t2_ovf_cnt2", int'(ovf_cnt), 1);
    cyc(0, 0, 0, 0, 1);
    lit("t2_d1", 1, 'h30, 3);
    cyc(0, 0, 0, 0, 1);
    lit("t2_d2", 1, 'h40, 2);
    cyc(0, 0, 0, 0, 1);
    lit("t2_d3", 1, 'h50, 1);
    cyc(0, 0, 0, 0, 1);
    lit("t2_d4", 0, 0, 0);

    // 3: recent-issue filter and its wrap
    cyc(1, 16'h0200, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 16'h0200, 0, 0, 0);
    chk("t3_dup1", int'(dup_cnt), 1);
    lit("t3_dup1", 0, 0, 0);
    cyc(1, 16'h0900, 1, 16'h0900, 0);
    chk("t3_dupdem", int'(dup_cnt), 2);
    cyc(1, 16'h0301, 0, 0, 1);
    cyc(1, 16'h0302, 0, 0, 1);
    cyc(1, 16'h0303, 0, 0, 1);
    cyc(1, 16'h0304, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 16'h0200, 0, 0, 0);
    lit("t3_wrap", 1, 'h200, 1);
    chk("t3_dup2", int'(dup_cnt), 2);
    cyc(0, 0, 0, 0, 1);

    // 4: demand squash of non-head only
    cyc(1, 16'h0010, 0, 0, 0);
    cyc(1, 16'h0020, 0, 0, 0);
    cyc(1, 16'h0030, 0, 0, 0);
    cyc(0, 0, 1, 16'h0020, 0);
    lit("t4_sq", 1, 'h10, 2);
    cyc(0, 0, 1, 16'h0010, 0);
    lit("t4_head", 1, 'h10, 2);

    // 5: pop + squash + push together
    do_reset();
    cyc(1, 16'h0010, 0, 0, 0);
    cyc(1, 16'h0020, 0, 0, 0);
    cyc(1, 16'h0030, 0, 0, 0);
    cyc(1, 16'h0060, 1, 16'h0030, 1);
    lit("t5_all", 1, 'h20, 2);
    cyc(0, 0, 0, 0, 1);
    lit("t5_next", 1, 'h60, 1);
    cyc(0, 0, 0, 0, 1);
    lit("t5_empty", 0, 0, 0);

    // 6: async reset mid-handshake, then dup saturation
    cyc(1, 16'h00A0, 0, 0, 0);
    cyc(1, 16'h00B0, 0, 0, 0);
    cyc(1, 16'h00C0, 0, 0, 0);
    cyc(1, 16'h00D0, 0, 0, 0);
    cyc(1, 16'h00E0, 0, 0, 0);
    chk("t6_ovf", int'(ovf_cnt), 1);
    cyc(1, 16'h00A0, 0, 0, 0);
    chk("t6_dup", int'(dup_cnt), 1);
    lit("t6_pre", 1, 'hA0, 4);
    pf_v = 1;
    pf_addr = 16'h00F0;
    mem_req_ready = 1;
    #2 rst_n = 0;
    #1;
    lit("t6_rst", 0, 0, 0);
    chk("t6_rst_dup", int'(dup_cnt), 0);
    chk("t6_rst_ovf", int'(ovf_cnt), 0);
    @(negedge clk);
    pf_v = 0;
    mem_req_ready = 0;
    rst_n = 1;
    cyc(0, 0, 0, 0, 1);
    lit("t6_norq", 0, 0, 0);
    cyc(1, 16'h0700, 0, 0, 0);
    repeat (260) cyc(1, 16'h0700, 0, 0, 0);
    chk("t6_sat", int'(dup_cnt), 255);
    lit("t6_sat", 1, 'h700, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
